// File: rtl/disp_digit_driver.sv
// disp_digit_driver: 7-segment digit driver placed after the digit scan counter.
// Holds a 4-digit hex value plus decimal points behind a shadow/active double
// buffer. Each scan slot selects its digit, decodes it (with optional
// leading-zero blanking) and registers the segment, decimal-point and anode
// outputs. Shadow data reaches the active buffer only at a frame boundary, so
// a frame is never drawn from a mix of old and new digits.
module disp_digit_driver #(
  parameter bit COMMIT_ON_FRAME = 1'b1,  // 1: commit at frame boundary, 0: commit as soon as pending
  parameter bit SEG_ACTIVE_LOW  = 1'b1   // 1: low = lit on Out_Seg/Out_Dp, 0: high = lit
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [1:0]  In_Sel,
  input  logic [3:0]  In_An,
  input  logic [15:0] Data_In,
  input  logic [3:0]  Dp_In,
  input  logic        Load,
  input  logic        Blank_En,
  output logic [6:0]  Out_Seg,
  output logic        Out_Dp,
  output logic [3:0]  Out_An,
  output logic        Pending,
  output logic        Commit
);

  // Segment patterns are built active-low internally; the output stage flips
  // them when the panel is active-high.
  localparam logic [6:0] SEG_OFF_LOW = 7'h7F;
  localparam logic [6:0] SEG_FLIP    = SEG_ACTIVE_LOW ? 7'h00 : 7'h7F;
  localparam logic       DP_FLIP     = ~SEG_ACTIVE_LOW;
  localparam logic [6:0] SEG_RST     = SEG_OFF_LOW ^ SEG_FLIP;
  localparam logic       DP_RST      = 1'b1 ^ DP_FLIP;
  localparam logic [3:0] AN_IDLE     = 4'b1111;

  // Hex digit to active-low segments, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [15:0] shadow_data;
  logic [3:0]  shadow_dp;
  logic [15:0] active_data;
  logic [3:0]  active_dp;
  logic [1:0]  prev_sel;

  logic        frame_boundary;
  logic        do_commit;
  logic [15:0] data_next;
  logic [3:0]  dp_next;
  logic [3:0]  digit;
  logic        upper_zero;
  logic        blank;
  logic [6:0]  seg_low;
  logic        dp_low;

  // Commit decision and the active value this slot is drawn from. The slot
  // that opens a new frame already shows the freshly committed value.
  // NOTE: every variable assigned in an always_comb gets a default at the top,
  // so no path can leave it holding a stale value and no latch is inferred.
  always_comb begin
    frame_boundary = (prev_sel == 2'b11) && (In_Sel == 2'b00);
    do_commit      = Pending && (COMMIT_ON_FRAME ? frame_boundary : 1'b1);
    data_next      = do_commit ? shadow_data : active_data;
    dp_next        = do_commit ? shadow_dp   : active_dp;
    digit          = data_next[{In_Sel, 2'b00} +: 4];
  end

  // Leading-zero test: the selected digit and every digit above it are zero.
  always_comb begin
    upper_zero = 1'b0;
    case (In_Sel)
      2'd1:    upper_zero = (data_next[15:4]  == 12'h000);
      2'd2:    upper_zero = (data_next[15:8]  == 8'h00);
      2'd3:    upper_zero = (data_next[15:12] == 4'h0);
      default: upper_zero = 1'b0;  // digit 0 always shows
    endcase
    blank = Blank_En && upper_zero;
  end

  // Active-low segment and decimal-point values for the current slot; an
  // all-off anode vector means the scanner is idle, so everything stays dark.
  always_comb begin
    seg_low = blank ? SEG_OFF_LOW : hex_to_seg(digit);
    dp_low  = ~dp_next[In_Sel];
    if (In_An == AN_IDLE) begin
      seg_low = SEG_OFF_LOW;
      dp_low  = 1'b1;
    end
  end

  assign Commit = do_commit;

  // Double buffer: Load fills the shadow, a commit copies shadow to active.
  // A Load in the commit cycle still commits the older shadow contents and
  // leaves the new data pending.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, whatever the statement order.
  // NOTE: both buffers sit on the async reset so a reset mid-operation throws
  // away pending and displayed data at once.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      active_data <= '0;
      active_dp   <= '0;
      Pending     <= 1'b0;
      prev_sel    <= 2'b00;
    end else begin
      prev_sel <= In_Sel;
      if (do_commit) begin
        active_data <= shadow_data;
        active_dp   <= shadow_dp;
      end
      if (Load) begin
        shadow_data <= Data_In;
        shadow_dp   <= Dp_In;
        Pending     <= 1'b1;
      end else if (do_commit) begin
        Pending <= 1'b0;
      end
    end
  end

  // Output register stage: one cycle of latency on segments, dp and anodes.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      Out_Seg <= SEG_RST;
      Out_Dp  <= DP_RST;
      Out_An  <= AN_IDLE;
    end else begin
      Out_Seg <= seg_low ^ SEG_FLIP;
      Out_Dp  <= dp_low ^ DP_FLIP;
      Out_An  <= In_An;
    end
  end

endmodule

// File: tb/tb_disp_digit_driver.sv
// Testbench for disp_digit_driver. Three instances share one set of inputs:
// frame commit / active-low, immediate commit / active-low, and frame commit /
// active-high. A behavioural model tracks both commit modes digit by digit.
module tb_disp_digit_driver;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [1:0]  In_Sel;
  logic [3:0]  In_An;
  logic [15:0] Data_In;
  logic [3:0]  Dp_In;
  logic        Load;
  logic        Blank_En;

  logic [6:0] f_seg, i_seg, h_seg;
  logic       f_dp, i_dp, h_dp;
  logic [3:0] f_an, i_an, h_an;
  logic       f_pend, i_pend, h_pend;
  logic       f_com, i_com, h_com;

  always #5 CLK = ~CLK;

  disp_digit_driver #(.COMMIT_ON_FRAME(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_frm (
    .CLK(CLK), .Reset(Reset), .In_Sel(In_Sel), .In_An(In_An), .Data_In(Data_In),
    .Dp_In(Dp_In), .Load(Load), .Blank_En(Blank_En), .Out_Seg(f_seg), .Out_Dp(f_dp),
    .Out_An(f_an), .Pending(f_pend), .Commit(f_com));

  disp_digit_driver #(.COMMIT_ON_FRAME(1'b0), .SEG_ACTIVE_LOW(1'b1)) dut_imm (
    .CLK(CLK), .Reset(Reset), .In_Sel(In_Sel), .In_An(In_An), .Data_In(Data_In),
    .Dp_In(Dp_In), .Load(Load), .Blank_En(Blank_En), .Out_Seg(i_seg), .Out_Dp(i_dp),
    .Out_An(i_an), .Pending(i_pend), .Commit(i_com));

  disp_digit_driver #(.COMMIT_ON_FRAME(1'b1), .SEG_ACTIVE_LOW(1'b0)) dut_hi (
    .CLK(CLK), .Reset(Reset), .In_Sel(In_Sel), .In_An(In_An), .Data_In(Data_In),
    .Dp_In(Dp_In), .Load(Load), .Blank_En(Blank_En), .Out_Seg(h_seg), .Out_Dp(h_dp),
    .Out_An(h_an), .Pending(h_pend), .Commit(h_com));

  localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model, index 0 = commit at frame boundary, 1 = commit immediately.
  logic [15:0] m_sh [2];
  logic [3:0]  m_shdp [2];
  logic [15:0] m_act [2];
  logic [3:0]  m_actdp [2];
  bit          m_pend [2];
  logic [1:0]  m_prev;

  logic [6:0]  e_seg [2];
  logic        e_dp [2];
  logic [3:0]  e_an;
  bit          e_com [2];
  logic        o_com [2];
  logic        o_com_h;

  logic [6:0]  obs_seg [4];
  logic [6:0]  exp_seg4 [4];
  int          obs_commits;

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_sh[m] = '0; m_shdp[m] = '0; m_act[m] = '0; m_actdp[m] = '0; m_pend[m] = 1'b0;
    end
    m_prev = 2'b00;
  endtask

  // One clock: predict from the current inputs, capture Commit mid-cycle,
  // then return 1 ns after the rising edge.
  task automatic tick();
    logic [15:0] na;
    logic [3:0]  nd;
    logic [3:0]  dig;
    bit          bnd, cnow, blank;
    int          top;
    @(negedge CLK);
    o_com[0] = f_com;
    o_com[1] = i_com;
    o_com_h  = h_com;
    if (Reset !== 1'b1) begin
      model_reset();
      for (int m = 0; m < 2; m++) begin
        e_seg[m] = 7'h7F; e_dp[m] = 1'b1; e_com[m] = 1'b0;
      end
      e_an = 4'b1111;
    end else begin
      for (int m = 0; m < 2; m++) begin
        bnd  = (m == 1) || (m_prev == 2'd3 && In_Sel == 2'd0);
        cnow = m_pend[m] && bnd;
        e_com[m] = cnow;
        na = cnow ? m_sh[m] : m_act[m];
        nd = cnow ? m_shdp[m] : m_actdp[m];
        top = -1;
        for (int k = 0; k < 4; k++) if (na[4*k +: 4] != 4'h0) top = k;
        dig   = na[4*In_Sel +: 4];
        blank = Blank_En && (In_Sel != 2'd0) && (int'(In_Sel) > top);
        if (In_An == 4'b1111) begin
          e_seg[m] = 7'h7F; e_dp[m] = 1'b1;
        end else begin
          e_seg[m] = blank ? 7'h7F : SEG_TAB[dig];
          e_dp[m]  = ~nd[In_Sel];
        end
        m_act[m] = na; m_actdp[m] = nd;
        if (Load) begin
          m_sh[m] = Data_In; m_shdp[m] = Dp_In; m_pend[m] = 1'b1;
        end else if (cnow) begin
          m_pend[m] = 1'b0;
        end
      end
      e_an   = In_An;
      m_prev = In_Sel;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic ld, input logic [15:0] d, input logic [3:0] dp);
    In_Sel  = sel;
    In_An   = ~(4'b0001 << sel);
    Load    = ld;
    Data_In = d;
    Dp_In   = dp;
  endtask

  // Scan slots 0..3 without loading, recording the frame-mode segments.
  task automatic scan_frame();
    obs_commits = 0;
    for (int k = 0; k < 4; k++) begin
      drive(2'(k), 1'b0, 16'($urandom), 4'($urandom));
      tick();
      obs_seg[k]  = f_seg;
      exp_seg4[k] = e_seg[0];
      if (o_com[0] === 1'b1) obs_commits++;
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      drive(2'($urandom), 1'b1, 16'($urandom), 4'($urandom));
      Blank_En = 1'($urandom);
      tick();
      n_checks++; if (f_seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %h expected 7f", f_seg); end
      n_checks++; if (f_dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b expected 1", f_dp); end
      n_checks++; if (f_an !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b expected 1111", f_an); end
      n_checks++; if (f_pend !== 1'b0 || i_pend !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b/%b expected 0", f_pend, i_pend); end
      n_checks++; if (o_com[0] !== 1'b0) begin n_fail++; $display("FAIL reset_commit: got %b expected 0", o_com[0]); end
      n_checks++; if (h_seg !== 7'h00 || h_dp !== 1'b0) begin n_fail++; $display("FAIL reset_hi_pol: got %h/%b expected 00/0", h_seg, h_dp); end
    end
    Reset = 1'b1;
  endtask

  task automatic test_commit_frame();
    logic [6:0] lit [4];
    lit[0] = 7'h19; lit[1] = 7'h30; lit[2] = 7'h24; lit[3] = 7'h79;
    Blank_En = 1'b0;
    drive(2'd0, 1'b1, 16'h1234, 4'h0);
    tick();
    n_checks++; if (f_pend !== 1'b1) begin n_fail++; $display("FAIL load_pending: got %b expected 1", f_pend); end
    for (int k = 1; k < 4; k++) begin
      drive(2'(k), 1'b0, 16'h0, 4'h0);
      tick();
      n_checks++; if (f_seg !== 7'h40) begin n_fail++; $display("FAIL pre_commit_seg slot %0d: got %h expected 40", k, f_seg); end
      n_checks++; if (o_com[0] !== 1'b0) begin n_fail++; $display("FAIL early_commit slot %0d: got %b expected 0", k, o_com[0]); end
    end
    scan_frame();
    n_checks++; if (obs_commits != 1) begin n_fail++; $display("FAIL commit_pulses: got %0d expected 1", obs_commits); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (obs_seg[k] !== lit[k]) begin n_fail++; $display("FAIL commit_seg slot %0d: got %h expected %h", k, obs_seg[k], lit[k]); end
    end
    n_checks++; if (f_pend !== 1'b0) begin n_fail++; $display("FAIL commit_pending_clear: got %b expected 0", f_pend); end
    scan_frame();
    n_checks++; if (obs_commits != 0) begin n_fail++; $display("FAIL extra_commit: got %0d expected 0", obs_commits); end
    n_checks++; if (obs_seg[2] !== 7'h24) begin n_fail++; $display("FAIL hold_seg: got %h expected 24", obs_seg[2]); end
  endtask

  task automatic test_blanking();
    logic [6:0] lit [4];
    lit[0] = 7'h40; lit[1] = 7'h12; lit[2] = 7'h7F; lit[3] = 7'h7F;
    Blank_En = 1'b0;
    drive(2'd0, 1'b1, 16'h0050, 4'h0);
    tick();
    for (int k = 1; k < 4; k++) begin drive(2'(k), 1'b0, 16'h0, 4'h0); tick(); end
    scan_frame();
    n_checks++; if (obs_commits != 1) begin n_fail++; $display("FAIL blank_commit: got %0d expected 1", obs_commits); end
    Blank_En = 1'b1;
    scan_frame();
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (obs_seg[k] !== lit[k]) begin n_fail++; $display("FAIL blank_on slot %0d: got %h expected %h", k, obs_seg[k], lit[k]); end
      n_checks++; if (obs_seg[k] !== exp_seg4[k]) begin n_fail++; $display("FAIL blank_model slot %0d: got %h expected %h", k, obs_seg[k], exp_seg4[k]); end
    end
    Blank_En = 1'b0;
    scan_frame();
    n_checks++; if (obs_seg[3] !== 7'h40 || obs_seg[2] !== 7'h40) begin n_fail++; $display("FAIL blank_off: got %h/%h expected 40/40", obs_seg[3], obs_seg[2]); end
  endtask

  task automatic test_back_to_back();
    drive(2'd0, 1'b0, 16'h0, 4'h0); tick();
    drive(2'd1, 1'b1, 16'hAAAA, 4'h0); tick();
    drive(2'd2, 1'b1, 16'hBBBB, 4'h0); tick();
    drive(2'd3, 1'b0, 16'h0, 4'h0); tick();
    n_checks++; if (f_seg !== 7'h40) begin n_fail++; $display("FAIL b2b_no_tear: got %h expected 40", f_seg); end
    scan_frame();
    n_checks++; if (obs_commits != 1) begin n_fail++; $display("FAIL b2b_commits: got %0d expected 1", obs_commits); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (obs_seg[k] !== 7'h03) begin n_fail++; $display("FAIL b2b_seg slot %0d: got %h expected 03", k, obs_seg[k]); end
    end
  endtask

  task automatic test_load_on_boundary();
    int pulses;
    drive(2'd0, 1'b0, 16'h0, 4'h0); tick();
    drive(2'd1, 1'b1, 16'h1111, 4'h0); tick();
    drive(2'd2, 1'b0, 16'h0, 4'h0); tick();
    drive(2'd3, 1'b0, 16'h0, 4'h0); tick();
    drive(2'd0, 1'b1, 16'h2222, 4'h0); tick();
    pulses = (o_com[0] === 1'b1) ? 1 : 0;
    n_checks++; if (o_com[0] !== 1'b1) begin n_fail++; $display("FAIL bnd_commit: got %b expected 1", o_com[0]); end
    n_checks++; if (f_pend !== 1'b1) begin n_fail++; $display("FAIL bnd_pending: got %b expected 1", f_pend); end
    n_checks++; if (f_seg !== 7'h79) begin n_fail++; $display("FAIL bnd_seg slot 0: got %h expected 79", f_seg); end
    for (int k = 1; k < 4; k++) begin
      drive(2'(k), 1'b0, 16'h0, 4'h0); tick();
      n_checks++; if (f_seg !== 7'h79) begin n_fail++; $display("FAIL bnd_seg slot %0d: got %h expected 79", k, f_seg); end
      n_checks++; if (f_pend !== 1'b1) begin n_fail++; $display("FAIL bnd_pending slot %0d: got %b expected 1", k, f_pend); end
    end
    scan_frame();
    pulses += obs_commits;
    n_checks++; if (pulses != 2) begin n_fail++; $display("FAIL bnd_pulses: got %0d expected 2", pulses); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (obs_seg[k] !== 7'h24) begin n_fail++; $display("FAIL bnd_next slot %0d: got %h expected 24", k, obs_seg[k]); end
    end
  endtask

  task automatic test_imm();
    logic [3:0] prev_an;
    drive(2'd0, 1'b0, 16'h0, 4'h0); tick();
    drive(2'd1, 1'b1, 16'h5A3C, 4'b0100); tick();
    n_checks++; if (o_com[1] !== 1'b0) begin n_fail++; $display("FAIL imm_load_cycle_commit: got %b expected 0", o_com[1]); end
    n_checks++; if (i_pend !== 1'b1) begin n_fail++; $display("FAIL imm_pending: got %b expected 1", i_pend); end
    drive(2'd2, 1'b0, 16'h0, 4'h0); tick();
    n_checks++; if (o_com[1] !== 1'b1) begin n_fail++; $display("FAIL imm_commit: got %b expected 1", o_com[1]); end
    n_checks++; if (i_pend !== 1'b0) begin n_fail++; $display("FAIL imm_pending_clear: got %b expected 0", i_pend); end
    for (int c = 0; c < 8; c++) begin
      drive(2'((c + 3) % 4), 1'b0, 16'h0, 4'h0);
      prev_an = In_An;
      tick();
      n_checks++; if (i_an !== prev_an) begin n_fail++; $display("FAIL imm_an: got %b expected %b", i_an, prev_an); end
      n_checks++; if (i_dp !== ((prev_an == 4'b1011) ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL imm_dp: got %b with anodes %b", i_dp, prev_an); end
      n_checks++; if (i_seg !== e_seg[1]) begin n_fail++; $display("FAIL imm_seg: got %h expected %h", i_seg, e_seg[1]); end
    end
    for (int c = 0; c < 8; c++) begin
      drive(2'(c % 4), 1'b0, 16'h0, 4'h0);
      In_An = (c == 3) ? 4'b1111 : 4'($urandom);
      prev_an = In_An;
      tick();
      n_checks++; if (i_an !== prev_an) begin n_fail++; $display("FAIL imm_an_raw: got %b expected %b", i_an, prev_an); end
      n_checks++; if (i_seg !== e_seg[1] || i_dp !== e_dp[1]) begin n_fail++; $display("FAIL imm_raw_an_out: got %h/%b expected %h/%b", i_seg, i_dp, e_seg[1], e_dp[1]); end
    end
  endtask

  task automatic test_reset_mid();
    drive(2'd0, 1'b1, 16'hFFFF, 4'hF); tick();
    for (int k = 1; k < 4; k++) begin drive(2'(k), 1'b0, 16'h0, 4'h0); tick(); end
    scan_frame();
    drive(2'd0, 1'b1, 16'h1234, 4'h3); tick();
    @(negedge CLK);
    #2 Reset = 1'b0;
    #1;
    model_reset();
    n_checks++; if (f_seg !== 7'h7F || f_dp !== 1'b1 || f_an !== 4'b1111) begin n_fail++; $display("FAIL async_reset_out: got %h/%b/%b expected 7f/1/1111", f_seg, f_dp, f_an); end
    n_checks++; if (f_pend !== 1'b0 || i_pend !== 1'b0) begin n_fail++; $display("FAIL async_reset_pending: got %b/%b expected 0", f_pend, i_pend); end
    tick(); tick();
    Reset = 1'b1;
    scan_frame();
    n_checks++; if (obs_commits != 0) begin n_fail++; $display("FAIL post_reset_commit: got %0d expected 0", obs_commits); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (obs_seg[k] !== 7'h40) begin n_fail++; $display("FAIL post_reset_seg slot %0d: got %h expected 40", k, obs_seg[k]); end
    end
    n_checks++; if (f_dp !== 1'b1) begin n_fail++; $display("FAIL post_reset_dp: got %b expected 1", f_dp); end
  endtask

  task automatic test_random();
    logic [1:0]  s;
    logic [15:0] d;
    int          r;
    s = 2'd0;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(99);
      if (r < 10) s = 2'($urandom); else s = s + 2'd1;
      d = 16'($urandom);
      case ($urandom_range(4))
        0: d = d & 16'h000F;
        1: d = d & 16'h00FF;
        2: d = d & 16'h0F0F;
        default: ;
      endcase
      drive(s, ($urandom_range(99) < 20), d, 4'($urandom));
      r = $urandom_range(99);
      if (r < 8) In_An = 4'b1111;
      else if (r < 12) In_An = 4'($urandom);
      if (i % 37 == 0) Blank_En = 1'($urandom);
      tick();
      n_checks++; if (f_seg !== e_seg[0] || f_dp !== e_dp[0]) begin n_fail++; $display("FAIL rnd_frm_out cyc %0d: got %h/%b expected %h/%b", i, f_seg, f_dp, e_seg[0], e_dp[0]); end
      n_checks++; if (f_an !== e_an || i_an !== e_an || h_an !== e_an) begin n_fail++; $display("FAIL rnd_an cyc %0d: got %b/%b/%b expected %b", i, f_an, i_an, h_an, e_an); end
      n_checks++; if (f_pend !== m_pend[0] || o_com[0] !== e_com[0]) begin n_fail++; $display("FAIL rnd_frm_ctl cyc %0d: got %b/%b expected %b/%b", i, f_pend, o_com[0], m_pend[0], e_com[0]); end
      n_checks++; if (i_seg !== e_seg[1] || i_dp !== e_dp[1]) begin n_fail++; $display("FAIL rnd_imm_out cyc %0d: got %h/%b expected %h/%b", i, i_seg, i_dp, e_seg[1], e_dp[1]); end
      n_checks++; if (i_pend !== m_pend[1] || o_com[1] !== e_com[1]) begin n_fail++; $display("FAIL rnd_imm_ctl cyc %0d: got %b/%b expected %b/%b", i, i_pend, o_com[1], m_pend[1], e_com[1]); end
      n_checks++; if (h_seg !== ~e_seg[0] || h_dp !== ~e_dp[0]) begin n_fail++; $display("FAIL rnd_hi_out cyc %0d: got %h/%b expected %h/%b", i, h_seg, h_dp, ~e_seg[0], ~e_dp[0]); end
      n_checks++; if (h_pend !== m_pend[0] || o_com_h !== e_com[0]) begin n_fail++; $display("FAIL rnd_hi_ctl cyc %0d: got %b/%b expected %b/%b", i, h_pend, o_com_h, m_pend[0], e_com[0]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    model_reset();
    drive(2'd0, 1'b0, 16'h0, 4'h0);
    Blank_En = 1'b0;
    #2 Reset = 1'b0;
    test_reset();
    test_commit_frame();
    test_blanking();
    test_back_to_back();
    test_load_on_boundary();
    test_imm();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_digit_driver.md
Name: disp_digit_driver

Overview:
- Display datapath stage directly downstream of the digit scan counter.
- Consumes the scanner's digit select and anode vector, and holds a 4-digit hex value behind a double buffer.
- Per scan slot, selects the digit, decodes it to 7-segment patterns with optional leading-zero blanking, and drives registered segment, decimal-point and anode outputs.
- New values are committed only at frame boundaries so the display never tears mid-scan.

Parameters:
- COMMIT_ON_FRAME, 1, 1: shadow→active copy waits for frame boundary; 0: copy on the cycle after Load.
- SEG_ACTIVE_LOW, 1, 1: Out_Seg/Out_Dp low = lit; 0: invert both (blank = 7'h00, Dp off = 0).

Ports:
- CLK  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-low reset
- In_Sel  in  2  digit index from scanner (0 = rightmost)
- In_An  in  4  anode vector from scanner, active-low
- Data_In  in  16  four hex digits, [3:0] = digit 0 … [15:12] = digit 3
- Dp_In  in  4  decimal points, bit i = digit i, 1 = lit
- Load  in  1  capture Data_In/Dp_In into shadow this cycle
- Blank_En  in  1  enable leading-zero blanking
- Out_Seg  out  7  segments, [0]=a … [6]=g
- Out_Dp  out  1  decimal point
- Out_An  out  4  anodes, In_An delayed 1 cycle
- Pending  out  1  shadow holds uncommitted data
- Commit  out  1  1-cycle pulse when active buffer updated

Behaviour:
- Reset (Reset=0, asynchronous):
  - shadow, active data and active dp = 0; Pending = 0; Commit = 0; prev_sel = 2'b00.
  - Out_Seg = 7'h7F, Out_Dp = 1, Out_An = 4'b1111 (SEG_ACTIVE_LOW=1).
  - Reset mid-operation discards both buffers immediately.
- Load:
  - Load=1 writes shadow ← {Data_In, Dp_In}; Pending ← 1.
  - Repeated Loads before commit overwrite the shadow; last value wins.
- Frame boundary:
  - Registered prev_sel = 2'b11 and In_Sel = 2'b00.
- Commit, COMMIT_ON_FRAME=1:
  - At a frame boundary with Pending=1: active ← shadow, Pending ← 0, Commit=1 for that cycle.
- Commit, COMMIT_ON_FRAME=0:
  - Any cycle with Pending=1 commits.
- Load and commit in the same cycle:
  - Active receives the shadow contents from before this cycle.
  - Shadow receives the new data; Pending stays 1; Commit=1.
- Output stage, 1 cycle latency, all outputs registered:
  - d = active digit[In_Sel]; Out_Seg ← decode(d) or blank; Out_Dp ← ~active_dp[In_Sel]; Out_An ← In_An.
- Decode, active-low, hex 0–F:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Blanking:
  - With Blank_En=1, digit i (i≥1) is blanked when it and all higher digits are 0.
  - Digit 0 is never blanked.
  - Blanked → Out_Seg = 7'h7F; Dp still follows active_dp.
- Idle anodes:
  - In_An = 4'b1111 (scanner in reset) → Out_Seg = 7'h7F, Out_Dp = 1 regardless of data.
- Width and wrap:
  - In_Sel wraps 3→0 naturally.
  - Values of In_An that are not one-hot-low are passed through unchanged; no checking.

Test Plan:
- Reset=0 with arbitrary inputs → Out_Seg=7'h7F, Out_Dp=1, Out_An=4'b1111, Pending=0; holds for ≥3 cycles.
- Release reset, Load Data_In=16'h1234, then scan 0..3 twice:
  - before the first 3→0 boundary → all segments 7'h40 (active = 0).
  - after the boundary → Commit pulses once; slot 0..3 shows 19, 30, 24, 79.
- Active=16'h0050, Blank_En=1:
  - digits 3 and 2 → 7'h7F; digit 1 → 12; digit 0 → 40.
  - Blank_En=0 → digits 3 and 2 → 40.
- Load 16'hAAAA, then 16'hBBBB within one frame → after the boundary every digit shows 03; single Commit pulse.
- Load asserted exactly on the boundary cycle with shadow=16'h1111, Data_In=16'h2222:
  - active=1111, Pending stays 1.
  - next boundary → active=2222, second Commit pulse.
- Dp_In=4'b0100, COMMIT_ON_FRAME=0:
  - Commit on the cycle after Load.
  - Out_Dp=0 only while Out_An=4'b1011; Out_An equals In_An delayed by 1 cycle throughout.
